// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: turns bytes received over the UART into register bus
// accesses and answers each command with one reply byte.
//   'W' addr data -> write, reply ACK
//   'R' addr      -> read, reply with the read data
//   anything else -> reply NAK
// A command abandoned part-way (no byte for TIMEOUT_CYCLES) is dropped silently.
module uart_reg_bridge #(
  parameter int          TIMEOUT_CYCLES = 5000000,
  parameter logic [7:0]  CMD_WR         = 8'h57,
  parameter logic [7:0]  CMD_RD         = 8'h52,
  parameter logic [7:0]  ACK            = 8'h4B,
  parameter logic [7:0]  NAK            = 8'h3F
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       drop
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_ADDR  = 3'd1,
    GET_DATA  = 3'd2,
    REG_WR    = 3'd3,
    REG_RD    = 3'd4,
    RD_CAP    = 3'd5,
    SEND      = 3'd6,
    SEND_WAIT = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic             is_wr_q, is_wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       txd_q, txd_d;
  logic             txv_q, txv_d;
  logic             we_q, we_d;
  logic             re_q, re_d;
  logic             seen_q, seen_d;
  logic             drop_s;

  // Next-state and next-output decode; a reply is launched straight away
  // when the transmitter is idle, otherwise it parks in SEND until it is.
  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    txd_d   = txd_q;
    seen_d  = seen_q;
    txv_d   = 1'b0;
    we_d    = 1'b0;
    re_d    = 1'b0;
    drop_s  = 1'b0;
    case (state_q)
      IDLE: begin
        seen_d = 1'b0;
        if (rx_valid) begin
          if (rx_data == CMD_WR) begin
            is_wr_d = 1'b1;
            cnt_d   = '0;
            state_d = GET_ADDR;
          end else if (rx_data == CMD_RD) begin
            is_wr_d = 1'b0;
            cnt_d   = '0;
            state_d = GET_ADDR;
          end else begin
            txd_d = NAK;
            if (!tx_busy) begin
              txv_d   = 1'b1;
              state_d = SEND_WAIT;
            end else begin
              state_d = SEND;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      GET_ADDR: begin
        if (rx_valid) begin
          addr_d = rx_data;
          cnt_d  = '0;
          if (is_wr_q) begin
            state_d = GET_DATA;
          end else begin
            re_d    = 1'b1;
            state_d = REG_RD;
          end
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GET_DATA: begin
        if (rx_valid) begin
          wdata_d = rx_data;
          cnt_d   = '0;
          we_d    = 1'b1;
          state_d = REG_WR;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REG_WR: begin
        drop_s = rx_valid;
        txd_d  = ACK;
        if (!tx_busy) begin
          txv_d   = 1'b1;
          state_d = SEND_WAIT;
        end else begin
          state_d = SEND;
        end
      end
      REG_RD: begin
        drop_s  = rx_valid;
        state_d = RD_CAP;
      end
      RD_CAP: begin
        drop_s = rx_valid;
        txd_d  = reg_rdata;
        if (!tx_busy) begin
          txv_d   = 1'b1;
          state_d = SEND_WAIT;
        end else begin
          state_d = SEND;
        end
      end
      SEND: begin
        drop_s = rx_valid;
        if (!tx_busy) begin
          txv_d   = 1'b1;
          state_d = SEND_WAIT;
        end else begin
          state_d = SEND;
        end
      end
      SEND_WAIT: begin
        drop_s = rx_valid;
        if (tx_busy) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          state_d = IDLE;
        end else begin
          state_d = SEND_WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any command or pending reply.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      txd_q   <= 8'h00;
      txv_q   <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      we_q    <= we_d;
      re_q    <= re_d;
      seen_q  <= seen_d;
    end
  end

  assign tx_valid  = txv_q;
  assign tx_data   = txd_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  // drop must mark the discarded byte in the very cycle it arrives.
  assign drop      = drop_s;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Randomised bench for uart_reg_bridge: a transaction-level model of the
// register file predicts every bus access and reply, with cycle latencies.
module tb_uart_reg_bridge;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rstb;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       drop;
  logic       force_busy;

  uart_reg_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstb(rstb), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_busy(tx_busy),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_re(reg_re), .reg_rdata(reg_rdata), .drop(drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter stand-in: busy for 1..4 cycles after each tx_valid.
  int bcnt = 0;
  always @(posedge clk) begin
    if (tx_valid) bcnt <= $urandom_range(4, 1);
    else if (bcnt > 0) bcnt <= bcnt - 1;
  end
  assign tx_busy = (bcnt != 0) || force_busy;

  // Register file stand-in: unwritten locations read as addr^5A.
  logic [7:0] bus_mem [256];
  bit         bus_wr  [256];
  always @(posedge clk) begin
    if (reg_we) begin
      bus_mem[reg_addr] <= reg_wdata;
      bus_wr[reg_addr]  <= 1'b1;
    end
    if (reg_re) reg_rdata <= bus_wr[reg_addr] ? bus_mem[reg_addr] : (reg_addr ^ 8'h5A);
  end

  // Event monitor, sampled mid-cycle.
  int n_we = 0, n_re = 0, n_tx = 0, n_drop = 0, n_excl = 0, n_hold = 0;
  int we_cyc = 0, re_cyc = 0, tx_cyc = 0, drop_cyc = 0;
  logic [7:0] we_addr = 8'h00, we_data = 8'h00, re_addr = 8'h00, tx_dat = 8'h00;
  always @(negedge clk) begin
    if (reg_we) begin
      n_we <= n_we + 1; we_cyc <= cyc; we_addr <= reg_addr; we_data <= reg_wdata;
    end
    if (reg_re) begin
      n_re <= n_re + 1; re_cyc <= cyc; re_addr <= reg_addr;
    end
    if (tx_valid) begin
      n_tx <= n_tx + 1; tx_cyc <= cyc; tx_dat <= tx_data;
    end
    if (drop) begin
      n_drop <= n_drop + 1; drop_cyc <= cyc;
    end
    if (reg_we && reg_re) n_excl <= n_excl + 1;
    if (rstb && bcnt != 0 && !tx_valid && tx_data !== tx_dat) n_hold <= n_hold + 1;
  end

  // Reference model of the register contents.
  logic [7:0] exp_mem [256];
  bit         exp_wr  [256];
  function automatic logic [7:0] exp_rd(input logic [7:0] a);
    return exp_wr[a] ? exp_mem[a] : (a ^ 8'h5A);
  endfunction

  int n_chk = 0, n_fail = 0;
  int b_we, b_re, b_tx, b_drop, b_excl, b_hold;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output int w);
    tick(1);
    rx_valid = 1'b1;
    rx_data  = b;
    w        = cyc;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic snap();
    b_we = n_we; b_re = n_re; b_tx = n_tx; b_drop = n_drop; b_excl = n_excl; b_hold = n_hold;
  endtask

  task automatic expect_ops(input string tag, input int we, input int re, input int tx, input int dr);
    check_eq({tag, "_we_cnt"}, n_we - b_we, we);
    check_eq({tag, "_re_cnt"}, n_re - b_re, re);
    check_eq({tag, "_tx_cnt"}, n_tx - b_tx, tx);
    check_eq({tag, "_drop_cnt"}, n_drop - b_drop, dr);
    check_eq({tag, "_excl_hold"}, (n_excl - b_excl) + (n_hold - b_hold), 0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int gap);
    int w;
    snap();
    send_byte(8'h57, w);
    tick(gap);
    send_byte(a, w);
    tick(gap);
    send_byte(d, w);
    tick(14);
    expect_ops("wr", 1, 0, 1, 0);
    check_eq("wr_we_lat", we_cyc, w + 1);
    check_eq("wr_addr", we_addr, a);
    check_eq("wr_data", we_data, d);
    check_eq("wr_tx_lat", tx_cyc, w + 2);
    check_eq("wr_reply", tx_dat, 8'h4B);
    exp_mem[a] = d;
    exp_wr[a]  = 1'b1;
  endtask

  task automatic do_read(input logic [7:0] a, input int gap);
    int w;
    snap();
    send_byte(8'h52, w);
    tick(gap);
    send_byte(a, w);
    tick(14);
    expect_ops("rd", 0, 1, 1, 0);
    check_eq("rd_re_lat", re_cyc, w + 1);
    check_eq("rd_addr", re_addr, a);
    check_eq("rd_tx_lat", tx_cyc, w + 3);
    check_eq("rd_reply", tx_dat, exp_rd(a));
  endtask

  task automatic do_bad(input logic [7:0] b);
    int w;
    snap();
    send_byte(b, w);
    tick(14);
    expect_ops("bad", 0, 0, 1, 0);
    check_eq("bad_tx_lat", tx_cyc, w + 1);
    check_eq("bad_reply", tx_dat, 8'h3F);
  endtask

  task automatic do_timeout(input bit wr, input logic [7:0] a);
    int w;
    snap();
    send_byte(wr ? 8'h57 : 8'h52, w);
    if (wr) send_byte(a, w);
    tick(TO + 5);
    expect_ops("tmo", 0, 0, 0, 0);
  endtask

  initial begin
    int w, wd, r;
    logic [7:0] b;
    rstb = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; force_busy = 1'b0;
    tick(3);
    check_eq("rst_outs", {tx_valid, tx_data, reg_addr, reg_wdata, reg_we, reg_re, drop}, 0);
    rstb = 1'b1;
    tick(2);

    // Directed cases from the plan.
    do_write(8'h10, 8'hA5, 0);
    do_read(8'h22, 0);
    do_read(8'h10, 0);
    do_bad(8'h41);
    do_timeout(1'b1, 8'h10);
    do_read(8'h22, 0);

    // Busy transmitter with a byte arriving while the reply waits.
    snap();
    force_busy = 1'b1;
    send_byte(8'h52, w);
    send_byte(8'h05, w);
    tick(4);
    send_byte(8'hA7, wd);
    tick(3);
    check_eq("busy_tx_held", n_tx - b_tx, 0);
    check_eq("busy_drop_cnt", n_drop - b_drop, 1);
    check_eq("busy_drop_cyc", drop_cyc, wd);
    force_busy = 1'b0;
    r = cyc;
    tick(14);
    expect_ops("busy", 0, 1, 1, 1);
    check_eq("busy_tx_lat", tx_cyc, r + 1);
    check_eq("busy_reply", tx_dat, exp_rd(8'h05));

    // Reset between address and data of a write.
    snap();
    send_byte(8'h57, w);
    send_byte(8'h33, w);
    rstb = 1'b0;
    tick(1);
    check_eq("midrst_outs", {tx_valid, tx_data, reg_addr, reg_wdata, reg_we, reg_re, drop}, 0);
    tick(2);
    rstb = 1'b1;
    tick(3);
    expect_ops("midrst", 0, 0, 0, 0);
    do_write(8'h01, 8'h02, 0);
    do_read(8'h01, 0);

    // Random mix of commands, inter-byte gaps kept inside the timeout.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(4, 0))
        0, 1: do_write(8'($urandom_range(15, 0)), 8'($urandom), $urandom_range(15, 0));
        2:    do_read(8'($urandom_range(15, 0)), $urandom_range(15, 0));
        3: begin
          b = 8'($urandom);
          if (b == 8'h57 || b == 8'h52) b = 8'h00;
          do_bad(b);
        end
        default: do_timeout(1'($urandom), 8'($urandom_range(15, 0)));
      endcase
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
